// File: rtl/uart_rx_8n1_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_8n1_pkg
// Shared constants and state encoding for the 8N1 UART receiver. The
// transmitter side of the link imports the same frame constants so both ends
// agree on bit period, data width and idle line level.
//
// Contents:
//   CLKS_PER_BIT_DEFAULT  clk cycles per bit (50 MHz / 20000 baud)
//   DATA_BITS             data bits per frame
//   LINE_IDLE             level of the serial line between frames
//   rxState_t             receiver FSM states
// ---------------------------------------------------------------------------
package uart_rx_8n1_pkg;

    localparam int   CLKS_PER_BIT_DEFAULT = 2500;
    localparam int   DATA_BITS            = 8;
    localparam logic LINE_IDLE            = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rxState_t;

endpackage

// File: rtl/uart_rx_8n1_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for the asynchronous serial input plus a falling-edge
// detector on the synchronised line. All flops reset to the idle line level,
// so releasing reset never fakes a start edge.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   i_line_rx  raw serial input (asynchronous to clk)
//   o_rx_s     synchronised serial line
//   o_fall     high for one cycle after o_rx_s goes from 1 to 0
// ---------------------------------------------------------------------------
module uart_rx_sync
    import uart_rx_8n1_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_line_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // r_meta absorbs metastability, r_sync is the usable line, r_prev is the
    // previous value of r_sync for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= LINE_IDLE;
            r_sync <= LINE_IDLE;
            r_prev <= LINE_IDLE;
        end else begin
            r_meta <= i_line_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_s = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_8n1.sv
// ---------------------------------------------------------------------------
// uart_rx_8n1
// UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle high.
// Samples each bit at its centre, delivers good bytes with a one-cycle done
// strobe and flags a low stop bit with a one-cycle error strobe.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit (>= 8, even)
//   CNT_W         bit-period counter width (2**CNT_W > CLKS_PER_BIT)
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   i_line_rx    serial input, asynchronous, idle high
//   o_data_rx    last correctly framed byte
//   o_rx_done    one-cycle pulse when o_data_rx updates
//   o_frame_err  one-cycle pulse when the stop bit is sampled low
//   o_busy       high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_8n1
    import uart_rx_8n1_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int CNT_W        = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_line_rx,
    output logic [7:0] o_data_rx,
    output logic       o_rx_done,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic w_rx_s;
    logic w_fall;

    rxState_t             r_state;
    rxState_t             w_nextState;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cntNext;
    logic [2:0]           r_idx;
    logic [2:0]           w_idxNext;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shiftNext;
    logic [DATA_BITS-1:0] r_data;
    logic [DATA_BITS-1:0] w_dataNext;
    logic                 r_done;
    logic                 w_doneNext;
    logic                 r_ferr;
    logic                 w_ferrNext;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .i_line_rx (i_line_rx),
        .o_rx_s    (w_rx_s),
        .o_fall    (w_fall)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Datapath registers. The strobes are registered so they appear the
    // cycle after the sample point that decided them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_cnt   <= w_cntNext;
            r_idx   <= w_idxNext;
            r_shift <= w_shiftNext;
            r_data  <= w_dataNext;
            r_done  <= w_doneNext;
            r_ferr  <= w_ferrNext;
        end
    end

    // Next-state and datapath logic. START waits half a bit so every later
    // sample lands at a bit centre; the counter restarts at each sample.
    // STOP returns to IDLE right at the stop-bit centre so a start edge
    // half a bit later (zero idle bits) is still caught. A low stop bit goes
    // to BREAK, which holds off start detection until the line is high again.
    always_comb begin
        w_nextState = r_state;
        w_cntNext   = r_cnt;
        w_idxNext   = r_idx;
        w_shiftNext = r_shift;
        w_dataNext  = r_data;
        w_doneNext  = 1'b0;
        w_ferrNext  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cntNext = '0;
                if (w_fall) begin
                    w_nextState = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cntNext = '0;
                    if (!w_rx_s) begin
                        w_nextState = ST_DATA;
                        w_idxNext   = '0;
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cntNext          = '0;
                    w_shiftNext[r_idx] = w_rx_s;
                    if (r_idx == 3'd7) begin
                        w_nextState = ST_STOP;
                    end else begin
                        w_idxNext = r_idx + 3'd1;
                    end
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cntNext = '0;
                    if (w_rx_s) begin
                        w_dataNext  = r_shift;
                        w_doneNext  = 1'b1;
                        w_nextState = ST_IDLE;
                    end else begin
                        w_ferrNext  = 1'b1;
                        w_nextState = ST_BREAK;
                    end
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                w_cntNext = '0;
                if (w_rx_s) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    assign o_data_rx   = r_data;
    assign o_rx_done   = r_done;
    assign o_frame_err = r_ferr;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_8n1
// Bench for uart_rx_8n1. A fast instance (16 clk per bit) is driven with
// directed frames; every frame sent pushes the strobe it must produce (kind,
// byte, cycle) onto a queue, and a per-cycle compare process matches DUT
// strobes and data_rx against that queue. A second instance at the default
// 2500 clk per bit receives one frame to pin the absolute latency.
// ---------------------------------------------------------------------------
module tb_uart_rx_8n1;

    localparam int CPB      = 16;
    localparam int SLOW_CPB = 2500;
    // Strobe expected 9.5 bits plus 3 clk (2 sync + 1 register) after the
    // raw start edge driven just after a rising clock edge.
    localparam int LAT      = (19 * CPB) / 2 + 3;
    localparam int TOL      = 1;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       lineRx   = 1'b1;
    logic       lineSlow = 1'b1;
    logic [7:0] dataRx;
    logic       rxDone;
    logic       frameErr;
    logic       busy;
    logic [7:0] dataSlow;
    logic       doneSlow;
    logic       errSlow;
    logic       busySlow;

    typedef struct {
        bit         isErr;
        logic [7:0] data;
        int         cyc;
    } rxEvent_t;

    rxEvent_t   expQ[$];
    logic [7:0] modelData   = 8'h00;
    int         cycleCount  = 0;
    int         checks      = 0;
    int         errors      = 0;
    int         doneCount   = 0;
    int         errCount    = 0;
    int         busyRun     = 0;
    int         lastBusyRun = 0;
    logic       prevDone    = 1'b0;
    logic       prevErr     = 1'b0;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB), .CNT_W(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_line_rx   (lineRx),
        .o_data_rx   (dataRx),
        .o_rx_done   (rxDone),
        .o_frame_err (frameErr),
        .o_busy      (busy)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(SLOW_CPB), .CNT_W(12)) dutSlow (
        .clk         (clk),
        .rst         (rst),
        .i_line_rx   (lineSlow),
        .o_data_rx   (dataSlow),
        .o_rx_done   (doneSlow),
        .o_frame_err (errSlow),
        .o_busy      (busySlow)
    );

    always #10 clk = ~clk;

    // Free-running cycle counter used for strobe timing expectations.
    initial begin
        forever begin
            @(posedge clk);
            cycleCount = cycleCount + 1;
        end
    end

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #(400000 * 20);
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic reportFail(input string name, input logic [31:0] act, input logic [31:0] req);
        errors = errors + 1;
        $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cycleCount);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            reportFail(name, act, req);
        end
    endtask

    // Compare process: every strobe must match the head of the expectation
    // queue in kind, byte and cycle; an overdue expectation is a missed
    // strobe; data_rx must always equal the last good byte of the model.
    initial begin
        rxEvent_t ev;
        forever begin
            @(negedge clk);
            if (rst) begin
                busyRun  = 0;
                prevDone = 1'b0;
                prevErr  = 1'b0;
            end else begin
                if (rxDone || frameErr) begin
                    checkOutput("strobeOverlap", 32'(rxDone & frameErr), 32'h0);
                    checkOutput("strobeWidth", 32'((rxDone & prevDone) | (frameErr & prevErr)), 32'h0);
                    checks = checks + 1;
                    if (expQ.size() == 0) begin
                        reportFail("unexpectedStrobe", 32'({rxDone, frameErr}), 32'h0);
                    end else begin
                        ev = expQ.pop_front();
                        checkOutput("strobeKind", 32'(frameErr), 32'(ev.isErr));
                        if (rxDone) begin
                            checkOutput("strobeData", 32'(dataRx), 32'(ev.data));
                        end
                        checks = checks + 1;
                        if (cycleCount < ev.cyc - TOL || cycleCount > ev.cyc + TOL) begin
                            reportFail("strobeTime", 32'(cycleCount), 32'(ev.cyc));
                        end
                        if (!ev.isErr) begin
                            modelData = ev.data;
                        end
                    end
                    if (rxDone) doneCount = doneCount + 1;
                    if (frameErr) errCount = errCount + 1;
                end else if (expQ.size() > 0 && cycleCount > expQ[0].cyc + TOL) begin
                    ev = expQ.pop_front();
                    checks = checks + 1;
                    reportFail("missedStrobe", 32'(cycleCount), 32'(ev.cyc));
                    if (!ev.isErr) begin
                        modelData = ev.data;
                    end
                end
                checkOutput("dataHold", 32'(dataRx), 32'(modelData));
                if (busy) begin
                    busyRun = busyRun + 1;
                end else if (busyRun > 0) begin
                    lastBusyRun = busyRun;
                    busyRun     = 0;
                end
                prevDone = rxDone;
                prevErr  = frameErr;
            end
        end
    end

    task automatic driveBit(input logic b, input int cycles);
        lineRx = b;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Sends one frame on the fast line and records the strobe it must cause.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int idleBits);
        rxEvent_t ev;
        ev.isErr = !stopBit;
        ev.data  = b;
        ev.cyc   = cycleCount + LAT;
        expQ.push_back(ev);
        driveBit(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            driveBit(b[i], CPB);
        end
        driveBit(stopBit, CPB);
        if (idleBits > 0) begin
            driveBit(1'b1, idleBits * CPB);
        end
    endtask

    task automatic waitIdle();
        for (int c = 0; c < 20 * CPB; c++) begin
            if (expQ.size() == 0 && !busy) break;
            @(negedge clk);
        end
        checkOutput("drainQueue", 32'(expQ.size()), 32'h0);
        checkOutput("drainBusy", 32'(busy), 32'h0);
    endtask

    initial begin
        logic [7:0] partial;
        logic [7:0] slowByte;
        int         startCyc;
        int         doneCyc;
        int         slowErrs;
        logic [7:0] slowData;
        bit         seen;

        $display("[TB] start");
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetData", 32'(dataRx), 32'h00);
        checkOutput("resetDone", 32'(rxDone), 32'h0);
        checkOutput("resetErr", 32'(frameErr), 32'h0);
        checkOutput("resetBusy", 32'(busy), 32'h0);
        rst = 1'b0;
        driveBit(1'b1, 2 * CPB);

        // "H" then "1" with one idle bit between.
        applyStimulus(8'h48, 1'b1, 1);
        applyStimulus(8'h31, 1'b1, 1);
        waitIdle();
        checkOutput("dataAfterH1", 32'(dataRx), 32'h31);
        checkOutput("doneCountH1", 32'(doneCount), 32'd2);
        checkOutput("errCountH1", 32'(errCount), 32'd0);

        // 0x00 then 0xFF with zero idle bits.
        applyStimulus(8'h00, 1'b1, 0);
        applyStimulus(8'hFF, 1'b1, 1);
        waitIdle();
        checkOutput("dataAfterB2B", 32'(dataRx), 32'hFF);
        checkOutput("doneCountB2B", 32'(doneCount), 32'd4);

        // 5 clk low glitch on the idle line.
        lastBusyRun = 0;
        driveBit(1'b0, 5);
        driveBit(1'b1, 2 * CPB);
        waitIdle();
        checkOutput("glitchBusySeen", 32'(lastBusyRun > 0), 32'h1);
        checkOutput("glitchBusyShort", 32'(lastBusyRun <= CPB / 2), 32'h1);
        checkOutput("glitchDoneCount", 32'(doneCount), 32'd4);
        checkOutput("glitchErrCount", 32'(errCount), 32'd0);

        // Bad stop bit, line held low 3 bits, then recovery with 0x5A.
        applyStimulus(8'hA5, 1'b0, 0);
        driveBit(1'b0, 3 * CPB);
        checkOutput("busyInBreak", 32'(busy), 32'h1);
        driveBit(1'b1, CPB);
        checkOutput("dataHeldAfterErr", 32'(dataRx), 32'hFF);
        checkOutput("errCountBad", 32'(errCount), 32'd1);
        applyStimulus(8'h5A, 1'b1, 1);
        waitIdle();
        checkOutput("dataAfterRecover", 32'(dataRx), 32'h5A);
        checkOutput("doneCountRecover", 32'(doneCount), 32'd5);

        // Reset during data bit 4 of 0x3C, then resend.
        partial = 8'h3C;
        driveBit(1'b0, CPB);
        for (int i = 0; i < 4; i++) begin
            driveBit(partial[i], CPB);
        end
        driveBit(partial[4], CPB / 2);
        checkOutput("busyMidFrame", 32'(busy), 32'h1);
        rst       = 1'b1;
        lineRx    = 1'b1;
        modelData = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midResetData", 32'(dataRx), 32'h00);
        checkOutput("midResetBusy", 32'(busy), 32'h0);
        checkOutput("midResetDone", 32'(rxDone), 32'h0);
        rst = 1'b0;
        driveBit(1'b1, 2 * CPB);
        checkOutput("dataAfterAbort", 32'(dataRx), 32'h00);
        applyStimulus(8'h3C, 1'b1, 1);
        waitIdle();
        checkOutput("dataAfterResend", 32'(dataRx), 32'h3C);
        checkOutput("doneCountResend", 32'(doneCount), 32'd6);
        checkOutput("errCountFinal", 32'(errCount), 32'd1);

        // Default-rate instance: 0x55, latency about 23750 clk.
        slowByte = 8'h55;
        slowErrs = 0;
        seen     = 1'b0;
        doneCyc  = 0;
        slowData = 8'h00;
        startCyc = cycleCount;
        fork
            begin
                for (int i = 0; i < 11; i++) begin
                    if (i == 0) lineSlow = 1'b0;
                    else if (i >= 9) lineSlow = 1'b1;
                    else lineSlow = slowByte[i - 1];
                    repeat (SLOW_CPB) @(posedge clk);
                    #1;
                end
            end
            begin
                for (int c = 0; c < 30000 && !seen; c++) begin
                    @(negedge clk);
                    if (errSlow) slowErrs = slowErrs + 1;
                    if (doneSlow) begin
                        seen     = 1'b1;
                        doneCyc  = cycleCount;
                        slowData = dataSlow;
                    end
                end
            end
        join
        checkOutput("slowSeen", 32'(seen), 32'h1);
        checkOutput("slowData", 32'(slowData), 32'h55);
        checkOutput("slowLatency", 32'((doneCyc - startCyc) >= 23746 && (doneCyc - startCyc) <= 23754), 32'h1);
        checkOutput("slowErrs", 32'(slowErrs), 32'h0);
        checkOutput("slowIdle", 32'(busySlow), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
